// File: rtl/gpio_ctrl.sv
// GPIO controller: direction/output registers, synchronized pad readback with
// per-bit programmable edge interrupts, W1C status and a registered irq line.
module gpio_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic [WIDTH-1:0] direction,
  output logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] pin_in,
  output logic             irq
);

  localparam logic [2:0] ADDR_DIR  = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_IER  = 3'd3;
  localparam logic [2:0] ADDR_ISR  = 3'd4;
  localparam logic [2:0] ADDR_EDGE = 3'd5;

  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] ier_r;
  logic [WIDTH-1:0] isr_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] prev_r;
  logic [1:0]       prime_r;
  logic [WIDTH-1:0] rdata_r;
  logic             rd_valid_r;
  logic             irq_r;

  logic             primed_s;
  logic [WIDTH-1:0] edge_evt_s;
  logic [WIDTH-1:0] isr_clr_s;
  logic [WIDTH-1:0] isr_nxt_s;
  logic [WIDTH-1:0] rd_mux_s;

  assign direction = dir_r;
  assign out_data  = out_r;
  assign rdata     = rdata_r;
  assign rd_valid  = rd_valid_r;
  assign irq       = irq_r;

  // Edge events on input pins only, gated until the synchronizers hold real pad data
  always_comb begin
    primed_s   = (prime_r == 2'd3);
    edge_evt_s = {WIDTH{1'b0}};
    if (primed_s) begin
      edge_evt_s = ~dir_r & ((edge_r & ~prev_r & sync2_r) |
                             (~edge_r & prev_r & ~sync2_r));
    end else begin
      edge_evt_s = {WIDTH{1'b0}};
    end
  end

  // W1C clear mask and next status; a same-cycle set overrides the clear
  always_comb begin
    isr_clr_s = {WIDTH{1'b0}};
    if (wr_en && (addr == ADDR_ISR)) begin
      isr_clr_s = wdata;
    end else begin
      isr_clr_s = {WIDTH{1'b0}};
    end
    isr_nxt_s = (isr_r & ~isr_clr_s) | edge_evt_s;
  end

  // Read data selection from current (pre-write) register contents
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    case (addr)
      ADDR_DIR:  rd_mux_s = dir_r;
      ADDR_OUT:  rd_mux_s = out_r;
      ADDR_IN:   rd_mux_s = sync2_r;
      ADDR_IER:  rd_mux_s = ier_r;
      ADDR_ISR:  rd_mux_s = isr_r;
      ADDR_EDGE: rd_mux_s = edge_r;
      default:   rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Software-writable configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r  <= {WIDTH{1'b0}};
      out_r  <= {WIDTH{1'b0}};
      ier_r  <= {WIDTH{1'b0}};
      edge_r <= {WIDTH{1'b0}};
    end else if (wr_en) begin
      case (addr)
        ADDR_DIR:  dir_r  <= wdata;
        ADDR_OUT:  out_r  <= wdata;
        ADDR_IER:  ier_r  <= wdata;
        ADDR_EDGE: edge_r <= wdata;
        default:   ;
      endcase
    end
  end

  // Pad synchronizer, previous-sample register and saturating prime counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      prev_r  <= {WIDTH{1'b0}};
      prime_r <= 2'd0;
    end else begin
      sync1_r <= pin_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (prime_r != 2'd3) begin
        prime_r <= prime_r + 2'd1;
      end else begin
        prime_r <= prime_r;
      end
    end
  end

  // Interrupt status and registered request line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_r <= {WIDTH{1'b0}};
      irq_r <= 1'b0;
    end else begin
      isr_r <= isr_nxt_s;
      irq_r <= |(isr_r & ier_r);
    end
  end

  // Read port: one-cycle latency, data held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r    <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rdata_r <= rd_mux_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_gpio_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rd_valid;
  logic [7:0] direction;
  logic [7:0] out_data;
  logic [7:0] pin_in;
  logic       irq;

  int vectors;
  int miscompares;
  logic [7:0] d;
  logic       v;

  gpio_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .direction(direction),
    .out_data(out_data), .pin_in(pin_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] dat);
    wr_en = 1'b1; addr = a; wdata = dat;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] dat, output logic vld);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    dat = rdata; vld = rd_valid;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    vectors++; if (direction !== 8'h00) begin miscompares++; $display("FAIL rst_direction: got %h want %h", direction, 8'h00); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data: got %h want %h", out_data, 8'h00); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b want 0", irq); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h want %h", rdata, 8'h00); end
    // release with EDGE=rising written immediately while all pads sit high
    rst_n = 1'b1;
    wr(3'd5, 8'hFF);
    idle(5);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL prime_isr: got %h want %h", d, 8'h00); end
    vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL prime_rd_valid: got %b want 1", v); end
    rd(3'd2, d, v);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL prime_in: got %h want %h", d, 8'hFF); end
  endtask

  task automatic test_rising_edge;
    pin_in[3] = 1'b0;
    idle(4);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL fall_ignored: got %h want %h", d, 8'h00); end
    pin_in[3] = 1'b1;
    idle(4);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL rise_isr: got %h want %h", d, 8'h08); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rise_irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_irq;
    wr(3'd3, 8'h08);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lag_set: got %b want 0", irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b want 1", irq); end
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL isr_read_no_clear: got %h want %h", d, 8'h08); end
    wr(3'd4, 8'h08);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_lag_clr: got %b want 1", irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clr: got %b want 0", irq); end
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL isr_w1c: got %h want %h", d, 8'h00); end
  endtask

  task automatic test_w1c_collision;
    wr(3'd5, 8'hFB);
    pin_in[2] = 1'b0;
    idle(4);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL fall_isr: got %h want %h", d, 8'h04); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL ier_mask: got %b want 0", irq); end
    pin_in[2] = 1'b1;
    idle(4);
    wr(3'd4, 8'h00);
    wr(3'd5, 8'hFB);
    wr(3'd0, 8'h00);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL isr_kept: got %h want %h", d, 8'h04); end
    // new falling edge reaches the detector exactly when the W1C is sampled
    pin_in[2] = 1'b0;
    @(negedge clk); @(negedge clk);
    wr(3'd4, 8'h04);
    idle(2);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL set_wins: got %h want %h", d, 8'h04); end
    wr(3'd4, 8'h04);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL clr_after_set: got %h want %h", d, 8'h00); end
  endtask

  task automatic test_output_pin;
    wr(3'd0, 8'h01);
    pin_in[0] = 1'b0;
    idle(3);
    rd(3'd2, d, v);
    vectors++; if (d !== 8'hFA) begin miscompares++; $display("FAIL outpin_in_low: got %h want %h", d, 8'hFA); end
    pin_in[0] = 1'b1;
    idle(3);
    rd(3'd2, d, v);
    vectors++; if (d !== 8'hFB) begin miscompares++; $display("FAIL outpin_in_high: got %h want %h", d, 8'hFB); end
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL outpin_no_isr: got %h want %h", d, 8'h00); end
  endtask

  task automatic test_dir_out;
    wr(3'd0, 8'h0F);
    vectors++; if (direction !== 8'h0F) begin miscompares++; $display("FAIL dir_write: got %h want %h", direction, 8'h0F); end
    wr(3'd1, 8'hA5);
    vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL out_write: got %h want %h", out_data, 8'hA5); end
    rd(3'd1, d, v);
    vectors++; if (d !== 8'hA5) begin miscompares++; $display("FAIL out_read: got %h want %h", d, 8'hA5); end
    vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL out_read_valid: got %b want 1", v); end
    @(negedge clk);
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL valid_pulse: got %b want 0", rd_valid); end
    vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL rdata_hold: got %h want %h", rdata, 8'hA5); end
    rd(3'd0, d, v);
    vectors++; if (d !== 8'h0F) begin miscompares++; $display("FAIL dir_read: got %h want %h", d, 8'h0F); end
    rd(3'd3, d, v);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL ier_read: got %h want %h", d, 8'h08); end
    rd(3'd5, d, v);
    vectors++; if (d !== 8'hFB) begin miscompares++; $display("FAIL edge_read: got %h want %h", d, 8'hFB); end
    wr(3'd7, 8'hFF);
    rd(3'd7, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL addr7_read: got %h want %h", d, 8'h00); end
    wr(3'd6, 8'hFF);
    rd(3'd6, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL addr6_read: got %h want %h", d, 8'h00); end
    vectors++; if (direction !== 8'h0F) begin miscompares++; $display("FAIL unmapped_dir: got %h want %h", direction, 8'h0F); end
    vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL unmapped_out: got %h want %h", out_data, 8'hA5); end
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd1; wdata = 8'h3C;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL rw_same_addr: got %h want %h", rdata, 8'hA5); end
    vectors++; if (out_data !== 8'h3C) begin miscompares++; $display("FAIL rw_out_updated: got %h want %h", out_data, 8'h3C); end
  endtask

  task automatic test_async_reset;
    wr(3'd0, 8'h00);
    pin_in[3] = 1'b0;
    idle(4);
    pin_in[3] = 1'b1;
    idle(4);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    wr(3'd0, 8'hFF);
    vectors++; if (direction !== 8'hFF) begin miscompares++; $display("FAIL pre_rst_dir: got %h want %h", direction, 8'hFF); end
    rd_en = 1'b1; addr = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (direction !== 8'h00) begin miscompares++; $display("FAIL async_dir: got %h want %h", direction, 8'h00); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL async_irq: got %b want 0", irq); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL async_out: got %h want %h", out_data, 8'h00); end
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    rd(3'd4, d, v);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL post_rst_isr: got %h want %h", d, 8'h00); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wdata = 8'h00;
    pin_in = 8'hFF;
    test_reset();
    test_rising_edge();
    test_irq();
    test_w1c_collision();
    test_output_pin();
    test_dir_out();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO bits; the register map SHALL be defined for WIDTH=8 only.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_en, input, 1 bit: register write strobe, one write per asserted cycle.
REQ-005 The block SHALL have port rd_en, input, 1 bit: register read strobe.
REQ-006 The block SHALL have port addr, input, 3 bits: register select.
REQ-007 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-008 The block SHALL have port rdata, output, WIDTH bits: registered read data.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse qualifying rdata.
REQ-010 The block SHALL have port direction, output, WIDTH bits: per-pin drive enable to the GPIO port, 1=output.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the value the GPIO port drives on output pins.
REQ-012 The block SHALL have port pin_in, input, WIDTH bits: raw pad readback from the GPIO port, asynchronous to clk.
REQ-013 The block SHALL have port irq, output, 1 bit: registered, level-high interrupt request.

Function
REQ-014 The register map SHALL be: 0 DIR (RW), 1 OUT (RW), 2 IN (RO), 3 IER (RW), 4 ISR (RW1C), 5 EDGE (RW, per-bit 1=rising, 0=falling); addresses 6-7 SHALL read 0 and ignore writes.
REQ-015 The direction and out_data outputs SHALL equal DIR and OUT directly, updating the cycle after the write.
REQ-016 pin_in SHALL pass through a 2-flop synchronizer per bit; IN SHALL return the second stage, giving 2-cycle input latency.
REQ-017 A third register, prev, SHALL hold the previous IN value for edge detection.
REQ-018 An edge event SHALL be flagged on bit i when DIR[i]=0, the block is primed, and either EDGE[i]=1 with prev[i]=0 and IN[i]=1, or EDGE[i]=0 with prev[i]=1 and IN[i]=0.
REQ-019 An edge event SHALL set ISR[i] on the next clock edge.
REQ-020 Writing ISR with wdata bit i=1 SHALL clear ISR[i]; writing 0 SHALL leave the bit unchanged.
REQ-021 When an edge event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-022 A 2-bit prime counter SHALL count from 0 to 3 after reset release and saturate; edge detection SHALL be enabled only when the count equals 3, suppressing spurious edges from reset-valued synchronizers.
REQ-023 Writes to DIR or EDGE SHALL NOT clear pending ISR bits.
REQ-024 Output pins (DIR=1) SHALL still be readable through IN but SHALL NOT raise edge events.
REQ-025 The irq output SHALL be registered as OR over (ISR AND IER), lagging ISR/IER changes by one cycle.
REQ-026 A read SHALL have 1-cycle latency: rd_en at cycle N SHALL produce rdata and rd_valid=1 at cycle N+1; rdata SHALL hold its value when rd_valid=0.
REQ-027 A simultaneous read and write to the same address SHALL return the pre-write value.
REQ-028 Reading ISR SHALL NOT clear it.

Reset
REQ-029 While rst_n=0, DIR, OUT, IER, ISR, EDGE, the synchronizer stages, prev, the prime counter, rdata, rd_valid and irq SHALL all be 0, making all pins inputs and no pins driven.
REQ-030 Reset assertion mid-operation SHALL take effect immediately without waiting for clk; release SHALL be treated as synchronous to clk by the instantiating logic.

Verification
REQ-031 Write DIR=0x0F then OUT=0xA5 -> direction=0x0F and out_data=0xA5 the cycle after each write; a read of addr 1 returns 0xA5 with rd_valid one cycle after rd_en.
REQ-032 Hold pin_in=0xFF through reset release with EDGE=0xFF -> ISR stays 0x00 (prime suppression); then drop pin_in[3] and raise it again -> ISR=0x08 two to three cycles after the rise.
REQ-033 Set IER=0x08 with ISR[3] pending -> irq=1 one cycle later; write ISR=0x08 -> ISR=0x00 and irq=0 one cycle after that.
REQ-034 Issue a W1C on ISR bit 2 in the same cycle as a new falling edge on bit 2 (EDGE[2]=0) -> ISR[2] remains 1.
REQ-035 Set DIR=0x01 and toggle pin_in[0] -> IN tracks the toggles and ISR[0] stays 0.
REQ-036 Assert rst_n low mid-transaction with DIR=0xFF and irq=1 -> direction=0x00 and irq=0 immediately, without waiting for a clk edge.
